sync_fifo_lsram: RTL and testbench

Single-clock, parametrised FIFO built on an inferred two-port RAM with a 1-cycle registered read, so it maps onto the LSRAM primitive. It generalises the fixed 64x64 dual-clock LSRAM wrapper used under COREFIFO. It adds full/empty flags, programmable almost-full/almost-empty thresholds, a fill level, sticky-free overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between the digitizer sample path and downstream packetisers.

---
 rtl/sync_fifo_lsram.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_lsram.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lsram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_lsram
// Brief    : Single-clock FIFO on an inferred registered-read two-port RAM,
//            with level/threshold flags and optional first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_lsram #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 6,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 56,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      W_DATA,
    input  logic                  W_EN,
    output logic                  FULL,
    output logic                  AFULL,
    output logic                  OVERFLOW,
    input  logic                  R_EN,
    output logic [WIDTH-1:0]      R_DATA,
    output logic                  R_VALID,
    output logic                  EMPTY,
    output logic                  AEMPTY,
    output logic                  UNDERFLOW,
    output logic [DEPTH_LOG2:0]   LEVEL
);

    localparam int                DEPTH        = 1 << DEPTH_LOG2;
    localparam int                LW           = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]     FULL_LEVEL   = LW'(DEPTH);
    localparam logic [LW-1:0]     AFULL_LEVEL  = LW'(AFULL_TH);
    localparam logic [LW-1:0]     AEMPTY_LEVEL = LW'(AEMPTY_TH);
    localparam logic [LW-1:0]     LEVEL_ONE    = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level;
    logic [WIDTH-1:0]      ram_q;
    logic                  wr_ok;
    logic                  ram_rd;
    logic                  pop;
    logic                  overflow_q;
    logic                  underflow_q;

    assign wr_ok     = W_EN && !FULL;
    assign FULL      = (level == FULL_LEVEL);
    assign AFULL     = (level >= AFULL_LEVEL);
    assign AEMPTY    = (level <= AEMPTY_LEVEL);
    assign LEVEL     = level;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

    // Storage array: no reset so it maps onto the RAM primitive.
    always_ff @(posedge CLK) begin
        if (!RESET && wr_ok) begin
            mem[wr_ptr] <= W_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ram_q <= '0;
        end else if (ram_rd) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
            overflow_q  <= W_EN && FULL;
            underflow_q <= R_EN && EMPTY;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic valid_q;

            assign ram_rd = R_EN && (level != '0);
            assign pop    = ram_rd;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= ram_rd;
                end
            end

            assign R_DATA  = ram_q;
            assign R_VALID = valid_q;
            assign EMPTY   = (level == '0);
        end else begin : g_fwft
            logic             ram_q_valid;
            logic             out_valid;
            logic [WIDTH-1:0] out_q;
            logic             out_load;
            logic [1:0]       staged;
            logic [LW-1:0]    ram_cnt;

            // Two-entry output stage: RAM output register feeds the holding register.
            assign pop      = R_EN && out_valid;
            assign out_load = ram_q_valid && (!out_valid || pop);
            assign staged   = {1'b0, ram_q_valid} + {1'b0, out_valid};
            assign ram_cnt  = level - LW'(staged);
            assign ram_rd   = (ram_cnt != '0) && (!ram_q_valid || out_load);

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    ram_q_valid <= 1'b0;
                    out_valid   <= 1'b0;
                    out_q       <= '0;
                end else begin
                    ram_q_valid <= ram_rd || (ram_q_valid && !out_load);
                    out_valid   <= out_load || (out_valid && !pop);
                    if (out_load) begin
                        out_q <= ram_q;
                    end
                end
            end

            assign R_DATA  = out_q;
            assign R_VALID = out_valid;
            assign EMPTY   = !out_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_lsram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_lsram
// Brief    : Directed bench for sync_fifo_lsram in standard and FWFT modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_lsram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic        s_rst, s_wen, s_ren;
    logic [63:0] s_wdata, s_rdata;
    logic        s_full, s_afull, s_ovf, s_rvalid, s_empty, s_aempty, s_unf;
    logic [6:0]  s_level;

    // FWFT instance signals
    logic        f_rst, f_wen, f_ren;
    logic [63:0] f_wdata, f_rdata;
    logic        f_full, f_afull, f_ovf, f_rvalid, f_empty, f_aempty, f_unf;
    logic [6:0]  f_level;

    int vectors     = 0;
    int miscompares = 0;

    sync_fifo_lsram #(.WIDTH(64), .DEPTH_LOG2(6), .FWFT(0), .AFULL_TH(56), .AEMPTY_TH(4)) dut_std (
        .CLK(clk), .RESET(s_rst), .W_DATA(s_wdata), .W_EN(s_wen), .FULL(s_full),
        .AFULL(s_afull), .OVERFLOW(s_ovf), .R_EN(s_ren), .R_DATA(s_rdata),
        .R_VALID(s_rvalid), .EMPTY(s_empty), .AEMPTY(s_aempty), .UNDERFLOW(s_unf),
        .LEVEL(s_level)
    );

    sync_fifo_lsram #(.WIDTH(64), .DEPTH_LOG2(6), .FWFT(1), .AFULL_TH(56), .AEMPTY_TH(4)) dut_fw (
        .CLK(clk), .RESET(f_rst), .W_DATA(f_wdata), .W_EN(f_wen), .FULL(f_full),
        .AFULL(f_afull), .OVERFLOW(f_ovf), .R_EN(f_ren), .R_DATA(f_rdata),
        .R_VALID(f_rvalid), .EMPTY(f_empty), .AEMPTY(f_aempty), .UNDERFLOW(f_unf),
        .LEVEL(f_level)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_rst = 1'b1; s_wen = 1'b0; s_ren = 1'b0; s_wdata = '0;
        f_rst = 1'b1; f_wen = 1'b0; f_ren = 1'b0; f_wdata = '0;
        tick();
        tick();

        // Reset state of both instances
        check("rst_level",  64'(s_level),  64'd0);
        check("rst_empty",  64'(s_empty),  64'd1);
        check("rst_aempty", 64'(s_aempty), 64'd1);
        check("rst_full",   64'(s_full),   64'd0);
        check("rst_afull",  64'(s_afull),  64'd0);
        check("rst_rvalid", 64'(s_rvalid), 64'd0);
        check("rst_rdata",  s_rdata,       64'd0);
        check("rst_ovf",    64'(s_ovf),    64'd0);
        check("rst_unf",    64'(s_unf),    64'd0);
        check("rst_f_empty",  64'(f_empty),  64'd1);
        check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        s_rst = 1'b0;
        f_rst = 1'b0;

        // Fill 64 words, check level and threshold flags
        for (int i = 1; i <= 64; i++) begin
            s_wen = 1'b1;
            s_wdata = 64'(i);
            tick();
            check("fill_level",  64'(s_level),  64'(i));
            check("fill_full",   64'(s_full),   (i == 64) ? 64'd1 : 64'd0);
            check("fill_afull",  64'(s_afull),  (i >= 56) ? 64'd1 : 64'd0);
            check("fill_aempty", 64'(s_aempty), (i <= 4)  ? 64'd1 : 64'd0);
        end
        s_wdata = 64'h41;
        tick();
        s_wen = 1'b0;
        check("ovf_pulse", 64'(s_ovf),   64'd1);
        check("ovf_level", 64'(s_level), 64'd64);
        tick();
        check("ovf_clear", 64'(s_ovf),   64'd0);

        // Drain 64 words, data 1 cycle after R_EN
        s_ren = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            check("drain_valid", 64'(s_rvalid), 64'd1);
            check("drain_data",  s_rdata,       64'(i));
        end
        s_ren = 1'b0;
        check("drain_empty", 64'(s_empty), 64'd1);
        check("drain_level", 64'(s_level), 64'd0);
        tick();
        check("drain_vdrop", 64'(s_rvalid), 64'd0);
        check("drain_hold",  s_rdata,       64'h40);

        // Underflow on empty, standard mode
        s_ren = 1'b1;
        tick();
        s_ren = 1'b0;
        check("unf_pulse", 64'(s_unf),    64'd1);
        check("unf_hold",  s_rdata,       64'h40);
        check("unf_valid", 64'(s_rvalid), 64'd0);
        tick();
        check("unf_clear", 64'(s_unf),    64'd0);

        // Simultaneous write+read at level 0
        s_wen = 1'b1; s_wdata = 64'h77; s_ren = 1'b1;
        tick();
        s_wen = 1'b0; s_ren = 1'b0;
        check("wr_rd0_unf",   64'(s_unf),    64'd1);
        check("wr_rd0_level", 64'(s_level),  64'd1);
        check("wr_rd0_valid", 64'(s_rvalid), 64'd0);
        s_ren = 1'b1;
        tick();
        s_ren = 1'b0;
        check("wr_rd0_data",  s_rdata,       64'h77);
        check("wr_rd0_lvl0",  64'(s_level),  64'd0);

        // Steady level 10 across pointer wrap
        for (int k = 0; k < 10; k++) begin
            s_wen = 1'b1;
            s_wdata = 64'h100 + 64'(k);
            tick();
        end
        for (int c = 0; c < 200; c++) begin
            s_wen = 1'b1; s_ren = 1'b1;
            s_wdata = 64'h10A + 64'(c);
            tick();
            check("wrap_level", 64'(s_level), 64'd10);
            check("wrap_data",  s_rdata,      64'h100 + 64'(c));
        end
        s_wen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("wrap_tail", s_rdata, 64'h1C8 + 64'(k));
        end
        s_ren = 1'b0;
        check("wrap_empty", 64'(s_empty), 64'd1);

        // Reset with level 20 and a read in flight
        for (int k = 0; k < 20; k++) begin
            s_wen = 1'b1;
            s_wdata = 64'h200 + 64'(k);
            tick();
        end
        s_wen = 1'b0; s_ren = 1'b1;
        tick();
        check("mrst_pre", s_rdata, 64'h200);
        s_rst = 1'b1; s_wen = 1'b1; s_wdata = 64'h555;
        tick();
        s_rst = 1'b0; s_wen = 1'b0; s_ren = 1'b0;
        check("mrst_level",  64'(s_level),  64'd0);
        check("mrst_empty",  64'(s_empty),  64'd1);
        check("mrst_rvalid", 64'(s_rvalid), 64'd0);
        check("mrst_rdata",  s_rdata,       64'd0);
        s_wen = 1'b1; s_wdata = 64'h999;
        tick();
        s_wen = 1'b0; s_ren = 1'b1;
        tick();
        s_ren = 1'b0;
        check("mrst_new", s_rdata, 64'h999);
        check("mrst_nv",  64'(s_rvalid), 64'd1);

        // FWFT single word latency
        f_wen = 1'b1; f_wdata = 64'hA5;
        tick();
        f_wen = 1'b0;
        check("fw_t0_valid", 64'(f_rvalid), 64'd0);
        check("fw_t0_level", 64'(f_level),  64'd1);
        tick();
        check("fw_t1_valid", 64'(f_rvalid), 64'd0);
        tick();
        check("fw_t2_valid", 64'(f_rvalid), 64'd1);
        check("fw_t2_data",  f_rdata,       64'hA5);
        check("fw_t2_empty", 64'(f_empty),  64'd0);
        f_ren = 1'b1;
        tick();
        f_ren = 1'b0;
        check("fw_pop_valid", 64'(f_rvalid), 64'd0);
        check("fw_pop_level", 64'(f_level),  64'd0);
        check("fw_pop_unf",   64'(f_unf),    64'd0);

        // FWFT underflow on empty
        f_ren = 1'b1;
        tick();
        f_ren = 1'b0;
        check("fw_unf_pulse", 64'(f_unf), 64'd1);
        check("fw_unf_hold",  f_rdata,    64'hA5);
        tick();
        check("fw_unf_clear", 64'(f_unf), 64'd0);

        // FWFT burst of 32 with R_EN held high
        for (int k = 0; k < 32; k++) begin
            f_wen = 1'b1;
            f_wdata = 64'h300 + 64'(k);
            tick();
        end
        f_wen = 1'b0;
        tick(); tick(); tick();
        check("fw_burst_level", 64'(f_level),  64'd32);
        check("fw_burst_head",  f_rdata,       64'h300);
        f_ren = 1'b1;
        for (int j = 1; j < 32; j++) begin
            tick();
            check("fw_burst_valid", 64'(f_rvalid), 64'd1);
            check("fw_burst_data",  f_rdata,       64'h300 + 64'(j));
            check("fw_burst_unf",   64'(f_unf),    64'd0);
        end
        tick();
        check("fw_burst_end_v",   64'(f_rvalid), 64'd0);
        check("fw_burst_end_unf", 64'(f_unf),    64'd0);
        check("fw_burst_end_lvl", 64'(f_level),  64'd0);
        tick();
        f_ren = 1'b0;
        check("fw_burst_unf1", 64'(f_unf), 64'd1);
        tick();
        check("fw_burst_unf0", 64'(f_unf), 64'd0);

        // FWFT reset with prefetched words
        for (int k = 0; k < 20; k++) begin
            f_wen = 1'b1;
            f_wdata = 64'h400 + 64'(k);
            tick();
        end
        f_wen = 1'b0;
        tick(); tick(); tick();
        check("fw_mrst_pre", f_rdata, 64'h400);
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        check("fw_mrst_level",  64'(f_level),  64'd0);
        check("fw_mrst_rvalid", 64'(f_rvalid), 64'd0);
        check("fw_mrst_rdata",  f_rdata,       64'd0);
        check("fw_mrst_empty",  64'(f_empty),  64'd1);
        f_wen = 1'b1; f_wdata = 64'hBEEF;
        tick();
        f_wen = 1'b0;
        tick();
        check("fw_mrst_t1", 64'(f_rvalid), 64'd0);
        tick();
        check("fw_mrst_t2", 64'(f_rvalid), 64'd1);
        check("fw_mrst_new", f_rdata, 64'hBEEF);
        f_ren = 1'b1;
        tick();
        f_ren = 1'b0;
        check("fw_mrst_lvl0", 64'(f_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
